// File: rtl/cpu_instrmem_ldr.sv
// cpu_instrmem_ldr: instruction memory filled by a little-endian byte loader, then served as registered fetches.
module cpu_instrmem_ldr #(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 2 ** (ADDR_W - 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_valid,
  input  logic [7:0]         ld_data,
  input  logic               ld_last,
  output logic               ld_ready,
  input  logic               reload,
  output logic               load_done,
  output logic               ld_ovf,
  input  logic               fetch_en,
  input  logic [ADDR_W-1:0]  instr_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_vld,
  output logic               err
);
  localparam int BPW = INSTR_W / 8;
  localparam int LB = $clog2(BPW);
  localparam int AW = $clog2(DEPTH);
  localparam int CAP = DEPTH * BPW;
  localparam int PW = $clog2(CAP) + 1;
  localparam logic [PW-1:0] CAP_P = PW'(CAP);
  localparam logic [ADDR_W:0] CAP_A = (ADDR_W + 1)'(CAP);

  typedef enum logic {LOAD, RUN} state_t;
  state_t state, state_nx;

  logic [PW-1:0] ptr;
  logic [INSTR_W-1:0] acc, wdata;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [LB-1:0] lane;
  logic take, in_rng, wr, ok;

  assign ld_ready = rst_n && state == LOAD;
  assign load_done = state == RUN;
  assign take = ld_valid && ld_ready;
  assign in_rng = ptr < CAP_P;
  assign lane = ptr[LB-1:0];
  // Upper lanes of acc are always zero, so OR-ing in the new byte also zero-fills a final partial word.
  assign wdata = acc | (INSTR_W'(ld_data) << (8 * lane));
  assign wr = take && in_rng && (&lane || ld_last);
  assign ok = state == RUN && instr_addr[LB-1:0] == '0 && {1'b0, instr_addr} < CAP_A;

  always_comb state_nx = state == LOAD ? (take && ld_last ? RUN : LOAD) : (reload ? LOAD : RUN);

  always_ff @(posedge clk) state <= rst_n ? state_nx : LOAD;

  // ptr saturates at CAP once the image overflows; lane bits no longer matter there.
  always_ff @(posedge clk) begin
    if (!rst_n || (state == RUN && reload)) begin
      ptr <= '0;
      acc <= '0;
      ld_ovf <= 1'b0;
    end else if (take) begin
      if (in_rng) ptr <= ptr + 1'b1;
      else ld_ovf <= 1'b1;
      acc <= (wr || !in_rng) ? '0 : wdata;
    end
  end

  always_ff @(posedge clk) if (wr) mem[AW'(ptr >> LB)] <= wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr <= '0;
      instr_vld <= 1'b0;
      err <= 1'b0;
    end else begin
      instr_vld <= fetch_en;
      err <= fetch_en && !ok;
      if (fetch_en) instr <= ok ? mem[AW'(instr_addr >> LB)] : '0;
    end
  end
endmodule

// File: tb/tb_cpu_instrmem_ldr.sv
// tb_cpu_instrmem_ldr: directed checks of loading, fetching, reload, overflow and reset (DEPTH = 4).
module tb_cpu_instrmem_ldr;
  logic clk = 0, rst_n = 0, ld_valid = 0, ld_last = 0, ld_ready, reload = 0;
  logic load_done, ld_ovf, fetch_en = 0, instr_vld, err;
  logic [7:0] ld_data = 0;
  logic [15:0] instr_addr = 0;
  logic [31:0] instr;
  int checks = 0, failures = 0;

  cpu_instrmem_ldr #(.ADDR_W(16), .INSTR_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .reload(reload), .load_done(load_done), .ld_ovf(ld_ovf),
    .fetch_en(fetch_en), .instr_addr(instr_addr), .instr(instr), .instr_vld(instr_vld), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en;
    logic [15:0] addr;
    logic [31:0] exp_instr;
    logic exp_err;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    ld_valid = 1; ld_data = b; ld_last = last;
    @(negedge clk);
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic fetch(input string name, input logic [15:0] a, input logic [31:0] ei, input logic ee);
    fetch_en = 1; instr_addr = a;
    @(negedge clk);
    fetch_en = 0;
    chk({name, " vld"}, 32'(instr_vld), 1);
    chk({name, " err"}, 32'(err), 32'(ee));
    chk({name, " instr"}, instr, ei);
  endtask

  initial begin
    vecs[0] = '{1, 16'h0000, 32'h04030201, 0};
    vecs[1] = '{1, 16'h0004, 32'h08070605, 0};
    vecs[2] = '{1, 16'h0002, 32'h00000000, 1};
    vecs[3] = '{1, 16'h0004, 32'h08070605, 0};
    vecs[4] = '{0, 16'h0000, 32'h08070605, 0};
    vecs[5] = '{1, 16'h0010, 32'h00000000, 1};
    vecs[6] = '{1, 16'h0001, 32'h00000000, 1};
    vecs[7] = '{1, 16'hFFFC, 32'h00000000, 1};
    vecs[8] = '{1, 16'h0000, 32'h04030201, 0};

    repeat (2) @(negedge clk);
    chk("rst instr", instr, 0);
    chk("rst vld", 32'(instr_vld), 0);
    chk("rst err", 32'(err), 0);
    chk("rst load_done", 32'(load_done), 0);
    chk("rst ovf", 32'(ld_ovf), 0);
    chk("rst ld_ready", 32'(ld_ready), 0);
    rst_n = 1;
    @(negedge clk);
    chk("ld_ready after rst", 32'(ld_ready), 1);

    fetch("fetch in LOAD", 16'h0000, 0, 1);

    for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
    chk("load_done t1", 32'(load_done), 1);
    chk("ld_ready in RUN", 32'(ld_ready), 0);

    for (int i = 0; i < 9; i++) begin
      fetch_en = vecs[i].en; instr_addr = vecs[i].addr;
      @(negedge clk);
      chk($sformatf("vec%0d vld", i), 32'(instr_vld), 32'(vecs[i].en));
      chk($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d instr", i), instr, vecs[i].exp_instr);
    end
    fetch_en = 0;

    fetch_en = 1; instr_addr = 0;
    @(negedge clk);
    chk("b2b0 instr", instr, 32'h04030201);
    chk("b2b0 vld", 32'(instr_vld), 1);
    instr_addr = 4;
    @(negedge clk);
    chk("b2b1 instr", instr, 32'h08070605);
    chk("b2b1 vld", 32'(instr_vld), 1);
    instr_addr = 0; reload = 1;
    @(negedge clk);
    fetch_en = 0; reload = 0;
    chk("b2b2 instr", instr, 32'h04030201);
    chk("b2b2 vld", 32'(instr_vld), 1);
    chk("b2b2 err", 32'(err), 0);
    chk("reload ld_ready", 32'(ld_ready), 1);
    chk("reload load_done", 32'(load_done), 0);

    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
    fetch("retain w0", 16'h0000, 32'h44332211, 0);
    fetch("retain w1", 16'h0004, 32'h08070605, 0);

    reload = 1;
    @(negedge clk);
    reload = 0;
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0); send(8'hEE, 0);
    fetch_en = 1; instr_addr = 0;
    send(8'hFF, 1);
    fetch_en = 0;
    chk("fetch with ld_last err", 32'(err), 1);
    chk("fetch with ld_last instr", instr, 0);
    send(8'h99, 0);
    fetch("partial w1", 16'h0004, 32'h0000FFEE, 0);
    fetch("partial w0", 16'h0000, 32'hDDCCBBAA, 0);

    reload = 1;
    @(negedge clk);
    reload = 0;
    for (int i = 0; i < 20; i++) begin
      send(8'(8'h30 + i), i == 19);
      if (i == 15) chk("ovf after 16", 32'(ld_ovf), 0);
      if (i == 16) chk("ovf after 17", 32'(ld_ovf), 1);
      if (i == 16) chk("ld_ready in ovf", 32'(ld_ready), 1);
    end
    chk("ovf load_done", 32'(load_done), 1);
    fetch("ovf addr 0x10", 16'h0010, 0, 1);
    fetch("ovf w3", 16'h000C, 32'h3F3E3D3C, 0);
    fetch("ovf w0", 16'h0000, 32'h33323130, 0);

    rst_n = 0;
    @(negedge clk);
    chk("rst2 ovf", 32'(ld_ovf), 0);
    chk("rst2 load_done", 32'(load_done), 0);
    chk("rst2 instr", instr, 0);
    rst_n = 1;
    send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    send(8'hB1, 1);
    fetch("midrst w0", 16'h0000, 32'h000000B1, 0);
    fetch("midrst w1", 16'h0004, 32'h37363534, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
